// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the architectural PC, fetches words over a req/ack
// memory handshake and hands them to decode over valid/ready, honouring PC redirects.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h00003000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        adel
);

   localparam logic [1:0] BOOT  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;
   localparam logic [1:0] DROP  = 2'd3;

   logic [1:0]  state_q,     state_d;
   logic [31:0] pc_q,        pc_d;
   logic [31:0] pendingPc_q, pendingPc_d;
   logic [31:0] inst_q,      inst_d;
   logic [31:0] instPc_q,    instPc_d;
   logic        instValid_q, instValid_d;
   logic        adel_q,      adel_d;

   logic [31:0] redirectTarget;
   logic        redirectMisaligned;

   assign redirectTarget     = {redirect_pc[31:2], 2'b00};
   assign redirectMisaligned = |redirect_pc[1:0];

   // A redirect overrides every other event; in DROP the outstanding stale
   // request must still be drained before the newest target is fetched.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      pendingPc_d = pendingPc_q;
      inst_d      = inst_q;
      instPc_d    = instPc_q;
      instValid_d = instValid_q;
      adel_d      = adel_q;

      if (redirect_valid) begin
         adel_d = redirectMisaligned;
         case (state_q)
            BOOT, HOLD: begin
               pc_d        = redirectTarget;
               instValid_d = 1'b0;
               state_d     = FETCH;
            end
            FETCH: begin
               if (imem_ack) begin
                  pc_d    = redirectTarget;
                  state_d = FETCH;
               end else begin
                  pendingPc_d = redirectTarget;
                  state_d     = DROP;
               end
            end
            DROP: begin
               pendingPc_d = redirectTarget;
               if (imem_ack) begin
                  pc_d    = redirectTarget;
                  state_d = FETCH;
               end
            end
            default: state_d = BOOT;
         endcase
      end else begin
         case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
               if (imem_ack) begin
                  inst_d      = imem_rdata;
                  instPc_d    = pc_q;
                  instValid_d = 1'b1;
                  pc_d        = pc_q + 32'd4;
                  state_d     = HOLD;
               end
            end
            HOLD: begin
               if (inst_ready) begin
                  instValid_d = 1'b0;
                  state_d     = FETCH;
               end
            end
            DROP: begin
               if (imem_ack) begin
                  pc_d    = pendingPc_q;
                  state_d = FETCH;
               end
            end
            default: state_d = BOOT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= BOOT;
         pc_q        <= RESET_PC;
         pendingPc_q <= 32'd0;
         inst_q      <= 32'd0;
         instPc_q    <= 32'd0;
         instValid_q <= 1'b0;
         adel_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pendingPc_q <= pendingPc_d;
         inst_q      <= inst_d;
         instPc_q    <= instPc_d;
         instValid_q <= instValid_d;
         adel_q      <= adel_d;
      end
   end

   assign imem_req   = (state_q == FETCH) || (state_q == DROP);
   assign imem_addr  = pc_q;
   assign inst_valid = instValid_q;
   assign inst       = inst_q;
   assign inst_pc    = instPc_q;
   assign adel       = adel_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a wait-state memory model plus hand-computed
// expectations for sequential fetch, decode stalls, redirects, alignment and reset.
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic        redirectValid;
   logic [31:0] redirectPc;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemAck;
   logic [31:0] imemRdata;
   logic        instValid;
   logic        instReady;
   logic [31:0] inst;
   logic [31:0] instPc;
   logic        adel;

   int          waitStates;
   int          waitCnt;
   logic [31:0] dataBase;
   logic        useAddr;
   int          compared;
   int          mismatched;

   fetch_unit #(.RESET_PC(32'h00003000)) dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirectValid),
      .redirect_pc    (redirectPc),
      .imem_req       (imemReq),
      .imem_addr      (imemAddr),
      .imem_ack       (imemAck),
      .imem_rdata     (imemRdata),
      .inst_valid     (instValid),
      .inst_ready     (instReady),
      .inst           (inst),
      .inst_pc        (instPc),
      .adel           (adel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory answers combinationally once a request has been held for waitStates cycles.
   always_comb begin
      imemAck   = imemReq && (waitCnt >= waitStates);
      imemRdata = dataBase | (useAddr ? imemAddr : 32'd0);
   end

   always @(posedge clk or posedge reset) begin
      if (reset)                  waitCnt <= 0;
      else if (!imemReq || imemAck) waitCnt <= 0;
      else                        waitCnt <= waitCnt + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic rv, input logic [31:0] rpc);
      redirectValid = rv;
      redirectPc    = rpc;
   endtask

   task automatic doReset();
      reset = 1'b1;
      applyStimulus(1'b0, 32'd0);
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic waitValid(input string tag, input logic [31:0] expPc, input logic [31:0] expInst);
      int n;
      n = 0;
      while (!instValid && n < 50) begin
         tick();
         n++;
      end
      checkOutput({tag, "_seen"}, {31'd0, instValid}, 32'd1);
      checkOutput({tag, "_pc"}, instPc, expPc);
      checkOutput({tag, "_inst"}, inst, expInst);
   endtask

   initial begin
      compared      = 0;
      mismatched    = 0;
      reset         = 1'b1;
      redirectValid = 1'b0;
      redirectPc    = 32'd0;
      instReady     = 1'b1;
      waitStates    = 0;
      dataBase      = 32'd0;
      useAddr       = 1'b0;

      // Reset values and zero-wait streaming, one instruction every two cycles.
      tick();
      checkOutput("rst_req",   {31'd0, imemReq},   32'd0);
      checkOutput("rst_addr",  imemAddr,           32'h00003000);
      checkOutput("rst_valid", {31'd0, instValid}, 32'd0);
      checkOutput("rst_inst",  inst,               32'd0);
      checkOutput("rst_pc",    instPc,             32'd0);
      checkOutput("rst_adel",  {31'd0, adel},      32'd0);
      doReset();
      checkOutput("boot_req", {31'd0, imemReq}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("t1_req",   {31'd0, imemReq},   32'd1);
         checkOutput("t1_addr",  imemAddr,           32'h00003000 + 32'(4 * k));
         checkOutput("t1_novld", {31'd0, instValid}, 32'd0);
         tick();
         checkOutput("t1_valid", {31'd0, instValid}, 32'd1);
         checkOutput("t1_ipc",   instPc,             32'h00003000 + 32'(4 * k));
         checkOutput("t1_inst",  inst,               32'd0);
         checkOutput("t1_noreq", {31'd0, imemReq},   32'd0);
         checkOutput("t1_adel",  {31'd0, adel},      32'd0);
      end

      // Decode stall holds the buffer and suppresses requests.
      dataBase  = 32'h8C010004;
      instReady = 1'b0;
      doReset();
      tick();
      tick();
      checkOutput("t2_valid", {31'd0, instValid}, 32'd1);
      for (int k = 0; k < 5; k++) begin
         tick();
         checkOutput("t2_hold_v",   {31'd0, instValid}, 32'd1);
         checkOutput("t2_hold_i",   inst,               32'h8C010004);
         checkOutput("t2_hold_pc",  instPc,             32'h00003000);
         checkOutput("t2_hold_req", {31'd0, imemReq},   32'd0);
      end
      instReady = 1'b1;
      tick();
      instReady = 1'b0;
      checkOutput("t2_rel_v",    {31'd0, instValid}, 32'd0);
      checkOutput("t2_rel_req",  {31'd0, imemReq},   32'd1);
      checkOutput("t2_rel_addr", imemAddr,           32'h00003004);
      tick();
      checkOutput("t2_next_pc", instPc, 32'h00003004);
      instReady = 1'b1;

      // Redirect while a 3-wait-state request is outstanding: drain, then refetch.
      waitStates = 3;
      dataBase   = 32'hC0DE0000;
      useAddr    = 1'b1;
      doReset();
      tick();
      waitValid("t3_first", 32'h00003000, 32'hC0DE3000);
      tick();
      checkOutput("t3_req3004", imemAddr, 32'h00003004);
      tick();
      applyStimulus(1'b1, 32'h00003100);
      tick();
      applyStimulus(1'b0, 32'd0);
      checkOutput("t3_drop_req",  {31'd0, imemReq}, 32'd1);
      checkOutput("t3_drop_addr", imemAddr,         32'h00003004);
      tick();
      checkOutput("t3_drop_ack",   {31'd0, imemAck},   32'd1);
      checkOutput("t3_drop_addr2", imemAddr,           32'h00003004);
      checkOutput("t3_drop_novld", {31'd0, instValid}, 32'd0);
      tick();
      checkOutput("t3_new_addr",  imemAddr,           32'h00003100);
      checkOutput("t3_new_novld", {31'd0, instValid}, 32'd0);
      waitValid("t3_redir", 32'h00003100, 32'hC0DE3100);

      // Redirect coincident with an ack, then newest redirect wins inside DROP.
      doReset();
      tick();
      for (int n = 0; n < 20 && !imemAck; n++) tick();
      checkOutput("t4_ack_seen", {31'd0, imemAck}, 32'd1);
      applyStimulus(1'b1, 32'h00003200);
      tick();
      checkOutput("t4_flush_v", {31'd0, instValid}, 32'd0);
      checkOutput("t4_addr",    imemAddr,           32'h00003200);
      applyStimulus(1'b1, 32'h00003280);
      tick();
      checkOutput("t4_stale", imemAddr, 32'h00003200);
      applyStimulus(1'b1, 32'h00003300);
      tick();
      applyStimulus(1'b0, 32'd0);
      waitValid("t4_final", 32'h00003300, 32'hC0DE3300);

      // Misaligned redirect sets adel and aligns the target; aligned redirect clears it.
      waitStates = 0;
      doReset();
      tick();
      applyStimulus(1'b1, 32'h00003102);
      tick();
      applyStimulus(1'b0, 32'd0);
      checkOutput("t5_adel_set", {31'd0, adel}, 32'd1);
      checkOutput("t5_addr",     imemAddr,      32'h00003100);
      waitValid("t5_mis", 32'h00003100, 32'hC0DE3100);
      checkOutput("t5_adel_hold", {31'd0, adel}, 32'd1);
      tick();
      applyStimulus(1'b1, 32'h00003000);
      tick();
      applyStimulus(1'b0, 32'd0);
      checkOutput("t5_adel_clr", {31'd0, adel}, 32'd0);
      checkOutput("t5_addr2",    imemAddr,      32'h00003000);

      // Reset asserted mid-fetch clears outputs at once and restarts at RESET_PC.
      waitStates = 3;
      doReset();
      tick();
      waitValid("t6_pre", 32'h00003000, 32'hC0DE3000);
      tick();
      tick();
      #2;
      reset = 1'b1;
      #1;
      checkOutput("t6_req",   {31'd0, imemReq},   32'd0);
      checkOutput("t6_addr",  imemAddr,           32'h00003000);
      checkOutput("t6_valid", {31'd0, instValid}, 32'd0);
      checkOutput("t6_inst",  inst,               32'd0);
      checkOutput("t6_ipc",   instPc,             32'd0);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("t6_boot_req", {31'd0, imemReq}, 32'd0);
      tick();
      checkOutput("t6_fetch_req",  {31'd0, imemReq}, 32'd1);
      checkOutput("t6_fetch_addr", imemAddr,         32'h00003000);
      waitValid("t6_restart", 32'h00003000, 32'hC0DE3000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Owns the architectural PC register and fetches instruction words from instruction memory through a req/ack handshake.
- Presents each fetched word, with its PC, to decode through a valid/ready handshake.
- Takes PC redirects from the next-PC logic (jump, jr, taken branch) as a one-cycle redirect strobe.
- Sits between the next-PC generator and decode, and sequentially consumes the next-PC value.

Parameters:
- RESET_PC, 32'h00003000, PC value loaded by reset; first fetch address.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- redirect_valid  input  1  one-cycle strobe; redirect_pc replaces the sequential PC.
- redirect_pc  input  32  target PC from next-PC logic.
- imem_req  output  1  instruction memory request.
- imem_addr  output  32  word address of the request; equals pc.
- imem_ack  input  1  memory has returned data this cycle.
- imem_rdata  input  32  instruction word, valid when imem_ack=1.
- inst_valid  output  1  inst/inst_pc hold a valid fetched instruction.
- inst_ready  input  1  decode accepts the instruction this cycle.
- inst  output  32  fetched instruction word.
- inst_pc  output  32  PC of inst.
- adel  output  1  sticky misaligned-redirect flag.

Behaviour:
- Reset (async, any cycle):
  - pc=RESET_PC, state=BOOT.
  - inst_valid=0, inst=0, inst_pc=0, adel=0.
  - Any in-flight request is abandoned; the memory must tolerate that.
- States:
  - BOOT→FETCH unconditionally after one clock.
  - imem_req=1 only in FETCH or DROP; imem_addr=pc at all times.
- FETCH:
  - imem_req held high and imem_addr held stable until imem_ack.
  - Ack may arrive in the same cycle as req (zero wait states) or any number of cycles later.
  - On ack: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4 (mod 2^32, wraps), state→HOLD.
- HOLD:
  - inst, inst_pc and inst_valid are held stable while inst_ready=0.
  - On inst_ready: inst_valid<=0, state→FETCH; the next request issues the following cycle.
  - Throughput is therefore one instruction per 2 cycles minimum.
- DROP:
  - A request is outstanding for a stale address. imem_req and imem_addr stay at the stale address until ack.
  - On ack: data is discarded, pc<=pending target, state→FETCH.
  - A pending-target register holds the redirect address while in DROP.
- Redirect (redirect_valid=1) has priority over every other event in the same cycle:
  - BOOT or HOLD: pc<=redirect_pc, inst_valid<=0 (buffer flushed even if inst_ready=1), state→FETCH.
  - FETCH with imem_ack=1 that cycle: rdata discarded, pc<=redirect_pc, state→FETCH. Nothing reaches decode.
  - FETCH with imem_ack=0: pending<=redirect_pc, state→DROP.
  - DROP: pending<=redirect_pc (the newest redirect wins). If ack arrives the same cycle, pc<=redirect_pc and state→FETCH.
- Alignment:
  - The target's bits [1:0] are forced to 00 wherever it is loaded.
  - If redirect_pc[1:0]!=0, adel<=1.
  - adel clears only on reset or on a later aligned redirect.
- Ack handling: imem_ack outside FETCH/DROP is ignored.
- pc+4 wrap: 32'hFFFFFFFC → 32'h00000000, with no flag.

Test Plan:
- Reset release, memory acks in the same cycle with 0x00000000, inst_ready=1 always → imem_addr sequence 0x3000, 0x3004, 0x3008 with inst_pc matching, one instruction every 2 cycles, adel=0.
- Decode stalls 5 cycles (inst_ready=0) with inst=0x8C010004 held → inst and inst_pc=0x3000 stable, no imem_req during the stall; the next request to 0x3004 follows the cycle after ready.
- Memory with 3 wait states, redirect_valid to 0x00003100 one cycle after req to 0x3004 → req stays at 0x3004 until ack, data discarded, next req to 0x3100, inst_pc=0x3100 delivered.
- Redirect to 0x3200 in the same cycle as an ack, then a second redirect to 0x3300 while in DROP → 0x3200 data never becomes valid, the only delivered PC is 0x3300.
- Redirect to 0x00003102 → adel=1, fetch address 0x3100; a later redirect to 0x3000 clears adel.
- Assert reset during a 3-wait-state FETCH → outputs clear immediately, imem_req=0 during BOOT, the fetch restarts at 0x3000.
